tag_dispatch: RTL and testbench

//  Upstream tag allocator for a bank of NUM_TAGS tag_logic instances. Accepts tile

---
 rtl/tag_dispatch.sv | 184 ++++++++++++++++++
 tb/tb_tag_dispatch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_dispatch.sv
// tag_dispatch: round-robin tag allocator with in-order retirement for a bank of
// tag_logic instances. Issues one tile per accept, tracks outstanding tags, flushes
// the last tile's tag and pulses block_done once the whole block has retired.
module tag_dispatch #(
  parameter int unsigned NUM_TAGS    = 2,
  parameter int unsigned LOGNUM_TAGS = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   block_start,
  output logic                   block_done,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_reuse,
  input  logic                   req_bias_prev_sw,
  input  logic                   req_ddr_pe_sw,
  input  logic                   req_last,
  output logic [LOGNUM_TAGS-1:0] req_tag,
  output logic [NUM_TAGS-1:0]    tag_req,
  output logic [NUM_TAGS-1:0]    tag_reuse,
  output logic [NUM_TAGS-1:0]    tag_bias_prev_sw,
  output logic [NUM_TAGS-1:0]    tag_ddr_pe_sw,
  output logic [NUM_TAGS-1:0]    tag_flush,
  input  logic [NUM_TAGS-1:0]    tag_ready,
  input  logic [NUM_TAGS-1:0]    tag_done,
  output logic [LOGNUM_TAGS:0]   outstanding,
  output logic [CNT_W-1:0]       tile_count
);

  localparam int unsigned OUT_W = LOGNUM_TAGS + 1;
  localparam int unsigned PTR_W = LOGNUM_TAGS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    done_ptr;
  logic                accept;
  logic                retire;
  logic                tile_clr;
  logic                block_done_nxt;
  logic [NUM_TAGS-1:0] wr_onehot;
  logic [NUM_TAGS-1:0] done_onehot;
  logic [NUM_TAGS-1:0] flush_set;
  logic [NUM_TAGS-1:0] flush_clr;

  // Request handshake: only in BUSY, with a free slot and the target tag ready.
  assign req_ready = (state == BUSY)
                   && (outstanding < OUT_W'(NUM_TAGS))
                   && tag_ready[wr_ptr];
  assign req_tag   = wr_ptr;
  assign accept    = req_valid && req_ready;

  // Retirement is strictly in order; a done on any other index, or with nothing
  // outstanding, is dropped.
  assign retire    = tag_done[done_ptr] && (outstanding != '0);

  assign wr_onehot   = NUM_TAGS'(1) << wr_ptr;
  assign done_onehot = NUM_TAGS'(1) << done_ptr;
  assign flush_set   = (accept && req_last) ? wr_onehot : '0;
  assign flush_clr   = retire ? done_onehot : '0;

  // Block state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Block sequencing: next state, tile counter clear and block_done request.
  always_comb begin
    state_nxt      = state;
    tile_clr       = 1'b0;
    block_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (block_start) begin
          state_nxt = BUSY;
          tile_clr  = 1'b1;
        end
      end
      BUSY: begin
        if (accept && req_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          state_nxt      = DONE;
          block_done_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // block_done is high for exactly the cycle spent in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      block_done <= 1'b0;
    end else begin
      block_done <= block_done_nxt;
    end
  end

  // Issue and retire pointers; both wrap naturally at NUM_TAGS (power of two).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      done_ptr <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (retire) begin
        done_ptr <= done_ptr + PTR_W'(1);
      end
    end
  end

  // Outstanding tag count; simultaneous accept and retire cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Tiles accepted in the current block; cleared on block start, wraps on overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tile_count <= '0;
    end else if (tile_clr) begin
      tile_count <= '0;
    end else if (accept) begin
      tile_count <= tile_count + CNT_W'(1);
    end
  end

  // One-cycle request pulse and qualifiers to the tag chosen on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_req          <= '0;
      tag_reuse        <= '0;
      tag_bias_prev_sw <= '0;
      tag_ddr_pe_sw    <= '0;
    end else begin
      tag_req          <= accept                      ? wr_onehot : '0;
      tag_reuse        <= (accept && req_reuse)        ? wr_onehot : '0;
      tag_bias_prev_sw <= (accept && req_bias_prev_sw) ? wr_onehot : '0;
      tag_ddr_pe_sw    <= (accept && req_ddr_pe_sw)    ? wr_onehot : '0;
    end
  end

  // Flush level for the last tile's tag, raised with its request, dropped on its retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_flush <= '0;
    end else begin
      tag_flush <= (tag_flush & ~flush_clr) | flush_set;
    end
  end

endmodule

// File: tb/tb_tag_dispatch.sv
// Directed bench for tag_dispatch with NUM_TAGS=2; expectations hand-derived per cycle.
module tb_tag_dispatch;

  localparam int unsigned NT = 2;
  localparam int unsigned LG = 1;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          reset;
  logic          block_start;
  logic          block_done;
  logic          req_valid;
  logic          req_ready;
  logic          req_reuse;
  logic          req_bias_prev_sw;
  logic          req_ddr_pe_sw;
  logic          req_last;
  logic [LG-1:0] req_tag;
  logic [NT-1:0] tag_req;
  logic [NT-1:0] tag_reuse;
  logic [NT-1:0] tag_bias_prev_sw;
  logic [NT-1:0] tag_ddr_pe_sw;
  logic [NT-1:0] tag_flush;
  logic [NT-1:0] tag_ready;
  logic [NT-1:0] tag_done;
  logic [LG:0]   outstanding;
  logic [CW-1:0] tile_count;

  int n_checks = 0;
  int n_pass   = 0;

  tag_dispatch #(
    .NUM_TAGS   (NT),
    .LOGNUM_TAGS(LG),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .block_start     (block_start),
    .block_done      (block_done),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_reuse       (req_reuse),
    .req_bias_prev_sw(req_bias_prev_sw),
    .req_ddr_pe_sw   (req_ddr_pe_sw),
    .req_last        (req_last),
    .req_tag         (req_tag),
    .tag_req         (tag_req),
    .tag_reuse       (tag_reuse),
    .tag_bias_prev_sw(tag_bias_prev_sw),
    .tag_ddr_pe_sw   (tag_ddr_pe_sw),
    .tag_flush       (tag_flush),
    .tag_ready       (tag_ready),
    .tag_done        (tag_done),
    .outstanding     (outstanding),
    .tile_count      (tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b0;
    block_start      = 1'b0;
    req_valid        = 1'b0;
    req_reuse        = 1'b0;
    req_bias_prev_sw = 1'b0;
    req_ddr_pe_sw    = 1'b0;
    req_last         = 1'b0;
    tag_ready        = '0;
    tag_done         = '0;

    // Reset state
    repeat (3) tick();
    check("rst_ready",   32'(req_ready), 32'd0);
    check("rst_done",    32'(block_done), 32'd0);
    check("rst_tag_req", 32'(tag_req), 32'd0);
    check("rst_reuse",   32'(tag_reuse), 32'd0);
    check("rst_bias",    32'(tag_bias_prev_sw), 32'd0);
    check("rst_ddr",     32'(tag_ddr_pe_sw), 32'd0);
    check("rst_flush",   32'(tag_flush), 32'd0);
    check("rst_req_tag", 32'(req_tag), 32'd0);
    check("rst_outst",   32'(outstanding), 32'd0);
    check("rst_tiles",   32'(tile_count), 32'd0);

    reset     = 1'b1;
    tag_ready = 2'b11;
    req_valid = 1'b1;
    #1;
    check("idle_ready", 32'(req_ready), 32'd0);
    tick();
    check("idle_ready2", 32'(req_ready), 32'd0);
    check("idle_tag_req", 32'(tag_req), 32'd0);

    // Start block; tiles back-to-back
    block_start = 1'b1;
    tick();
    block_start = 1'b0;
    #1;
    check("t0_ready", 32'(req_ready), 32'd1);
    check("t0_tag",   32'(req_tag), 32'd0);
    tick();
    check("t0_tag_req", 32'(tag_req), 32'h1);
    check("t0_outst",   32'(outstanding), 32'd1);
    check("t0_tiles",   32'(tile_count), 32'd1);

    req_reuse     = 1'b1;
    req_ddr_pe_sw = 1'b1;
    #1;
    check("t1_ready", 32'(req_ready), 32'd1);
    check("t1_tag",   32'(req_tag), 32'd1);
    tick();
    check("t1_tag_req", 32'(tag_req), 32'h2);
    check("t1_reuse",   32'(tag_reuse), 32'h2);
    check("t1_ddr",     32'(tag_ddr_pe_sw), 32'h2);
    check("t1_bias",    32'(tag_bias_prev_sw), 32'h0);
    check("t1_outst",   32'(outstanding), 32'd2);
    check("t1_tiles",   32'(tile_count), 32'd2);

    // Outstanding capped at NUM_TAGS: stall
    req_reuse     = 1'b0;
    req_ddr_pe_sw = 1'b0;
    #1;
    check("cap_ready", 32'(req_ready), 32'd0);
    tick();
    check("cap_tag_req", 32'(tag_req), 32'h0);
    check("cap_reuse",   32'(tag_reuse), 32'h0);
    check("cap_outst",   32'(outstanding), 32'd2);
    check("cap_tiles",   32'(tile_count), 32'd2);

    // Retire tag 0
    tag_done = 2'b01;
    #1;
    check("ret0_ready", 32'(req_ready), 32'd0);
    tick();
    check("ret0_outst", 32'(outstanding), 32'd1);

    // Accept tag 0 while retiring tag 1 in the same cycle
    tag_done = 2'b10;
    #1;
    check("both_ready", 32'(req_ready), 32'd1);
    check("both_tag",   32'(req_tag), 32'd0);
    tick();
    tag_done = 2'b00;
    check("both_outst",   32'(outstanding), 32'd1);
    check("both_tag_req", 32'(tag_req), 32'h1);
    check("both_tiles",   32'(tile_count), 32'd3);

    // Out-of-order done (index 1 while tag 0 is oldest) is ignored
    req_valid = 1'b0;
    tag_done  = 2'b10;
    tick();
    tag_done = 2'b00;
    check("ooo_outst",   32'(outstanding), 32'd1);
    check("ooo_tag_req", 32'(tag_req), 32'h0);

    // Last tile on tag 1
    req_valid        = 1'b1;
    req_last         = 1'b1;
    req_bias_prev_sw = 1'b1;
    #1;
    check("last_ready", 32'(req_ready), 32'd1);
    check("last_tag",   32'(req_tag), 32'd1);
    tick();
    req_last         = 1'b0;
    req_bias_prev_sw = 1'b0;
    check("last_tag_req", 32'(tag_req), 32'h2);
    check("last_bias",    32'(tag_bias_prev_sw), 32'h2);
    check("last_flush",   32'(tag_flush), 32'h2);
    check("last_outst",   32'(outstanding), 32'd2);
    check("last_tiles",   32'(tile_count), 32'd4);
    #1;
    check("drain_ready0", 32'(req_ready), 32'd0);

    // block_start in DRAIN ignored
    block_start = 1'b1;
    tick();
    block_start = 1'b0;
    check("drain_tag_req", 32'(tag_req), 32'h0);
    check("drain_flush",   32'(tag_flush), 32'h2);
    check("drain_tiles",   32'(tile_count), 32'd4);
    check("drain_done0",   32'(block_done), 32'd0);

    tag_done = 2'b01;
    tick();
    tag_done = 2'b00;
    check("drain_outst1", 32'(outstanding), 32'd1);
    check("drain_flush1", 32'(tag_flush), 32'h2);
    #1;
    check("drain_ready1", 32'(req_ready), 32'd0);

    tag_done = 2'b10;
    tick();
    tag_done = 2'b00;
    check("drain_outst0", 32'(outstanding), 32'd0);
    check("drain_flush0", 32'(tag_flush), 32'h0);
    check("drain_done1",  32'(block_done), 32'd0);

    tick();
    check("blk_done",  32'(block_done), 32'd1);
    check("blk_tiles", 32'(tile_count), 32'd4);
    tick();
    check("blk_done_end", 32'(block_done), 32'd0);
    #1;
    check("post_ready", 32'(req_ready), 32'd0);
    tick();
    check("post_done", 32'(block_done), 32'd0);
    req_valid = 1'b0;

    // New block; reset while draining
    block_start = 1'b1;
    tick();
    block_start = 1'b0;
    check("b2_tiles", 32'(tile_count), 32'd0);
    tag_ready = 2'b10;
    req_valid = 1'b1;
    #1;
    check("b2_not_ready", 32'(req_ready), 32'd0);
    tag_ready = 2'b11;
    req_last  = 1'b1;
    #1;
    check("b2_ready", 32'(req_ready), 32'd1);
    check("b2_tag",   32'(req_tag), 32'd0);
    tick();
    req_last  = 1'b0;
    req_valid = 1'b0;
    check("b2_flush",   32'(tag_flush), 32'h1);
    check("b2_tag_req", 32'(tag_req), 32'h1);
    check("b2_outst",   32'(outstanding), 32'd1);
    tick();
    check("b2_flush_hold", 32'(tag_flush), 32'h1);

    req_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_flush", 32'(tag_flush), 32'h0);
    check("mid_rst_req",   32'(tag_req), 32'h0);
    check("mid_rst_outst", 32'(outstanding), 32'd0);
    check("mid_rst_tiles", 32'(tile_count), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_done",  32'(block_done), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("after_rst_ready", 32'(req_ready), 32'd0);
    check("after_rst_done",  32'(block_done), 32'd0);
    check("after_rst_tag",   32'(req_tag), 32'd0);
    tick();
    check("after_rst_done2", 32'(block_done), 32'd0);
    req_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
